link_rx: RTL and testbench

// - UART receive stage facing the serial link transmitter: deserialises 8N1 frames from the USB-UART RX pin.
// - Buffers received bytes in a small FIFO and presents them to the CPU-side bus logic with valid/pop.
// - Runs entirely in the CPU clock domain and times bits with an internal baud counter.
// - Sticky error flags report framing and overrun faults.

---
 rtl/link_rx_pkg.sv | 15 +
 rtl/link_rx_if.sv | 29 ++
 rtl/link_rx_fifo.sv | 63 ++++++
 rtl/link_rx.sv | 152 +++++++++++++++
 tb/tb_link_rx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/link_rx_pkg.sv
// Shared definitions for the UART receive slice: FSM state encoding and frame constants.
package link_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   localparam int unsigned UART_BITS            = 8;
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 36;

endpackage

// File: rtl/link_rx_if.sv
// CPU-side read bus of the UART receiver: head byte, valid/pop handshake, sticky errors.
interface link_rx_if;

   logic       pop;
   logic       clear;
   logic [7:0] rd_data;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   modport master (
      output pop,
      output clear,
      input  rd_data,
      input  valid,
      input  frame_err,
      input  overrun
   );

   modport slave (
      input  pop,
      input  clear,
      output rd_data,
      output valid,
      output frame_err,
      output overrun
   );

endinterface

// File: rtl/link_rx_fifo.sv
// Synchronous receive FIFO with registered head byte; pop is applied before push.
module link_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             valid,
   output logic             full,
   output logic             dropped
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      wr_next;
   logic [AW:0]      rd_next;
   logic             empty;
   logic             do_pop;
   logic             do_push;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign valid = ~empty;

   always_comb begin
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      dropped = push & full & ~do_pop;
      rd_next = rd_ptr + {{AW{1'b0}}, do_pop};
      wr_next = wr_ptr + {{AW{1'b0}}, do_push};
   end

   // Head register: bypass the incoming byte when it lands in the slot that becomes head.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         if (do_push && (wr_ptr == rd_next)) begin
            rd_data <= wr_data;
         end else if (do_pop && (wr_ptr != rd_next)) begin
            rd_data <= mem[rd_next[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/link_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, baud-timed FSM, receive FIFO, sticky errors.
// Optional LINK_RX_IRQ_EN adds a one-cycle irq pulse on push or error.
module link_rx
   import link_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   link_rx_if.slave   bus
`ifdef LINK_RX_IRQ_EN
   ,
   output logic       irq
`endif
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BW = $clog2(UART_BITS);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(UART_BITS - 1);

   rx_state_t            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [UART_BITS-1:0] shift_q, shift_d;
   logic                 rx_m, rx_s;
   logic                 push;
   logic                 ferr_set;
   logic                 fifo_full;
   logic                 fifo_drop;
   logic                 frame_err_q;
   logic                 overrun_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = RX_IDLE;
               end else begin
                  state_d = RX_DATA;
                  bit_d   = '0;
               end
            end
         end
         RX_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[UART_BITS-1:1]};
               bit_d   = bit_q + BW'(1);
               if (bit_q == BIT_LAST) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  push    = 1'b1;
                  state_d = RX_IDLE;
               end else begin
                  ferr_set = 1'b1;
                  state_d  = RX_BREAK;
               end
            end
         end
         RX_BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   link_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_BITS)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .wr_data (shift_q),
      .pop     (bus.pop),
      .rd_data (bus.rd_data),
      .valid   (bus.valid),
      .full    (fifo_full),
      .dropped (fifo_drop)
   );

   // A new error outranks a simultaneous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= ferr_set  | (frame_err_q & ~bus.clear);
         overrun_q   <= fifo_drop | (overrun_q & ~bus.clear & ~fifo_full) | (overrun_q & ~bus.clear & fifo_full);
      end
   end

   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;

`ifdef LINK_RX_IRQ_EN
   // Every push is either accepted or an overrun, so push alone covers both events.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         irq <= 1'b0;
      end else begin
         irq <= push | ferr_set;
      end
   end
`endif

endmodule

// File: tb/tb_link_rx.sv
// Directed bench for link_rx: serial frames in, scoreboard of expected bytes read back via pop.
module tb_link_rx;

   localparam int CPB   = 36;
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic rx    = 1'b1;

   link_rx_if bus ();

`ifdef LINK_RX_IRQ_EN
   logic irq;
`endif

   link_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .rx    (rx),
      .bus   (bus)
`ifdef LINK_RX_IRQ_EN
      ,
      .irq   (irq)
`endif
   );

   always #5 clock = ~clock;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] sb [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drives one full frame; pop is raised for the single iteration pop_at (-1 for none).
   task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int pop_at);
      int b;
      for (int c = 0; c < 10 * CPB; c++) begin
         b = c / CPB;
         if (b == 0)      rx = 1'b0;
         else if (b <= 8) rx = data[b-1];
         else             rx = stop_bit;
         bus.pop = (c == pop_at);
         step();
      end
      bus.pop = 1'b0;
      if (stop_bit) rx = 1'b1;
   endtask

   task automatic wait_valid(input string tag, input int max_cycles);
      for (int i = 0; i < max_cycles && !bus.valid; i++) step();
      @(negedge clock);
      check(tag, {31'd0, bus.valid}, 32'd1);
   endtask

   task automatic read_byte(input string tag);
      logic [7:0] exp;
      wait_valid({tag, "_valid"}, 4 * CPB);
      if (sb.size() > 0) begin
         exp = sb.pop_front();
         check(tag, {24'd0, bus.rd_data}, {24'd0, exp});
      end else begin
         check({tag, "_sb_empty"}, 32'd1, {31'd0, bus.valid ^ 1'b1});
      end
      step();
      bus.pop = 1'b1;
      step();
      bus.pop = 1'b0;
   endtask

   task automatic clear_flags();
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.pop   = 1'b0;
      bus.clear = 1'b0;
      repeat (3) step();
      @(negedge clock);
      check("rst_valid",     {31'd0, bus.valid},     32'd0);
      check("rst_rd_data",   {24'd0, bus.rd_data},   32'd0);
      check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      check("rst_overrun",   {31'd0, bus.overrun},   32'd0);
      step();
      reset = 1'b0;
      repeat (5) step();

      // Single byte
      sb.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, -1);
      read_byte("a5");
      @(negedge clock);
      check("a5_valid_after_pop", {31'd0, bus.valid},     32'd0);
      check("a5_no_frame_err",    {31'd0, bus.frame_err}, 32'd0);
      step();

      // Five back-to-back bytes into a depth-4 FIFO
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, -1);
         if (i <= DEPTH) sb.push_back(8'(i));
      end
      @(negedge clock);
      check("burst_overrun",   {31'd0, bus.overrun},   32'd1);
      check("burst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      step();
      for (int i = 1; i <= DEPTH; i++) read_byte("burst_data");
      @(negedge clock);
      check("burst_drained", {31'd0, bus.valid}, 32'd0);
      step();
      clear_flags();
      @(negedge clock);
      check("overrun_cleared", {31'd0, bus.overrun}, 32'd0);
      step();

      // Low stop bit followed by a long break
      send_frame(8'h3C, 1'b0, -1);
      repeat (100 * CPB) step();
      @(negedge clock);
      check("break_frame_err", {31'd0, bus.frame_err}, 32'd1);
      check("break_no_push",   {31'd0, bus.valid},     32'd0);
      step();
      rx = 1'b1;
      repeat (2 * CPB) step();
      sb.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, -1);
      read_byte("after_break");
      @(negedge clock);
      check("after_break_once", {31'd0, bus.valid}, 32'd0);
      step();
      clear_flags();
      @(negedge clock);
      check("frame_err_cleared", {31'd0, bus.frame_err}, 32'd0);
      step();

      // Short glitch on idle line
      rx = 1'b0;
      repeat (10) step();
      rx = 1'b1;
      repeat (3 * CPB) step();
      @(negedge clock);
      check("glitch_no_byte",  {31'd0, bus.valid},     32'd0);
      check("glitch_no_ferr",  {31'd0, bus.frame_err}, 32'd0);
      check("glitch_no_ovr",   {31'd0, bus.overrun},   32'd0);
      step();

      // Full FIFO with pop landing on the push cycle of 0x77
      for (int i = 0; i < DEPTH; i++) begin
         send_frame(8'h10 + 8'(i), 1'b1, -1);
         sb.push_back(8'h10 + 8'(i));
      end
      @(negedge clock);
      check("full_head", {24'd0, bus.rd_data}, {24'd0, sb.pop_front()});
      step();
      send_frame(8'h77, 1'b1, 9 * CPB + CPB / 2 + 3);
      sb.push_back(8'h77);
      @(negedge clock);
      check("poppush_no_overrun", {31'd0, bus.overrun}, 32'd0);
      step();
      for (int i = 0; i < DEPTH; i++) read_byte("poppush_data");
      @(negedge clock);
      check("poppush_drained", {31'd0, bus.valid}, 32'd0);
      step();

      // Reset in the middle of a frame
      send_frame(8'h5A, 1'b1, -1);
      @(negedge clock);
      check("pre_reset_valid", {31'd0, bus.valid}, 32'd1);
      step();
      for (int c = 0; c < 4 * CPB; c++) begin
         rx = (c < CPB) ? 1'b0 : 1'b1;
         step();
      end
      reset = 1'b1;
      repeat (2) step();
      @(negedge clock);
      check("midrst_valid",     {31'd0, bus.valid},     32'd0);
      check("midrst_rd_data",   {24'd0, bus.rd_data},   32'd0);
      check("midrst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      check("midrst_overrun",   {31'd0, bus.overrun},   32'd0);
      step();
      rx    = 1'b1;
      reset = 1'b0;
      repeat (12 * CPB) step();
      @(negedge clock);
      check("midrst_no_partial", {31'd0, bus.valid}, 32'd0);
      step();
      sb.push_back(8'h12);
      send_frame(8'h12, 1'b1, -1);
      read_byte("post_reset");
      @(negedge clock);
      check("sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
